// File: rtl/mix_columns_if.sv
// Block-in / block-out handshake bundle for the MixColumns engine.
// The master drives blocks in and accepts results; the slave is the engine.
interface mix_columns_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inverse;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    modport master (
        output in_valid, in_state, in_inverse, in_bypass, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, in_inverse, in_bypass, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/mix_columns_engine.sv
// Multi-cycle AES MixColumns / InvMixColumns engine with a bypass for the final round.
// Transforms COLS_PER_CYCLE columns of the working register in place per BUSY cycle.
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    mix_columns_if.slave bus
);

    localparam int         N        = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_CNT = 2'(N - 1);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e       state_r;
    state_e       state_nxt_s;
    logic [1:0]   col_cnt_r;
    logic [127:0] work_r;
    logic [127:0] work_nxt_s;
    logic         inv_r;
    logic         byp_r;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // All constant multiples are built from one xtime chain per byte.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (k)
            4'h1:    return x;
            4'h2:    return x2;
            4'h3:    return x2 ^ x;
            4'h9:    return x8 ^ x;
            4'hb:    return x8 ^ x2 ^ x;
            4'hd:    return x8 ^ x4 ^ x;
            4'he:    return x8 ^ x4 ^ x2;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] gf_row(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic [7:0] a3,
                                          input logic inv);
        if (inv) begin
            return gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
        end else begin
            return gf_mul(a0, 4'h2) ^ gf_mul(a1, 4'h3) ^ gf_mul(a2, 4'h1) ^ gf_mul(a3, 4'h1);
        end
    endfunction

    // Row 0 lives in the most significant byte of the column.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gf_row(a0, a1, a2, a3, inv), gf_row(a1, a2, a3, a0, inv),
                gf_row(a2, a3, a0, a1, inv), gf_row(a3, a0, a1, a2, inv)};
    endfunction

    // Next-state decode for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) state_nxt_s = BUSY;
                else              state_nxt_s = IDLE;
            end
            BUSY: begin
                if (col_cnt_r == LAST_CNT) state_nxt_s = DONE;
                else                       state_nxt_s = BUSY;
            end
            DONE: begin
                if (bus.out_ready) state_nxt_s = IDLE;
                else               state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // In-place column update for the group selected by col_cnt.
    always_comb begin
        work_nxt_s = work_r;
        for (int c = 0; c < 4; c++) begin
            if (((c / COLS_PER_CYCLE) == int'(col_cnt_r)) && !byp_r) begin
                work_nxt_s[127 - 32*c -: 32] = mix_col(work_r[127 - 32*c -: 32], inv_r);
            end else begin
                work_nxt_s[127 - 32*c -: 32] = work_r[127 - 32*c -: 32];
            end
        end
    end

    // State, counter, working register and latched mode bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            col_cnt_r <= 2'd0;
            work_r    <= 128'd0;
            inv_r     <= 1'b0;
            byp_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        work_r    <= bus.in_state;
                        inv_r     <= bus.in_inverse;
                        byp_r     <= bus.in_bypass;
                        col_cnt_r <= 2'd0;
                    end
                end
                BUSY: begin
                    work_r    <= work_nxt_s;
                    col_cnt_r <= col_cnt_r + 2'd1;
                end
                default: begin
                    work_r <= work_r;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.busy      = (state_r != IDLE);
    assign bus.out_state = work_r;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed bench for mix_columns_engine: three instances (1, 2, 4 columns per cycle)
// share data inputs; the single-column instance carries the full scenario set.
module tb_mix_columns_engine;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         v1 = 1'b0;
    logic         v2 = 1'b0;
    logic         v4 = 1'b0;
    logic [127:0] st = 128'd0;
    logic         inv = 1'b0;
    logic         byp = 1'b0;
    logic         ordy = 1'b0;
    int           cyc = 0;
    int           tests_run = 0;
    int           tests_failed = 0;

    localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] INV_IN  = {4{32'hd5d5d7d6}};
    localparam logic [127:0] INV_OUT = {4{32'hd4d4d4d5}};
    localparam logic [127:0] BYP_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] C6      = {4{32'hc6c6c6c6}};
    localparam logic [127:0] MIX_IN  = 128'h2d26314c_db135345_f20a225c_01010101;
    localparam logic [127:0] MIX_OUT = 128'h4d7ebdf8_8e4da1bc_9fdc589d_01010101;

    mix_columns_if b1 ();
    mix_columns_if b2 ();
    mix_columns_if b4 ();

    assign b1.in_valid = v1;  assign b1.in_state = st;  assign b1.in_inverse = inv;
    assign b1.in_bypass = byp; assign b1.out_ready = ordy;
    assign b2.in_valid = v2;  assign b2.in_state = st;  assign b2.in_inverse = inv;
    assign b2.in_bypass = byp; assign b2.out_ready = ordy;
    assign b4.in_valid = v4;  assign b4.in_state = st;  assign b4.in_inverse = inv;
    assign b4.in_bypass = byp; assign b4.out_ready = ordy;

    mix_columns_engine #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    mix_columns_engine #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    mix_columns_engine #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // One block through dut1; lat = 0 means no out_valid within the bound.
    task automatic run_block(input logic [127:0] s, input logic i, input logic b,
                             output logic [127:0] res, output int lat);
        @(negedge clk);
        st = s; inv = i; byp = b; ordy = 1'b1; v1 = 1'b1;
        for (int w = 0; w < 20; w++) begin
            if (b1.in_ready) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1 v1 = 1'b0;
        lat = 0;
        res = 128'd0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (b1.out_valid) begin
                lat = k;
                res = b1.out_state;
                break;
            end
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if (b1.in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", b1.in_ready);
        end
        tests_run++;
        if (b1.out_valid !== 1'b0 || b1.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got out_valid=%b busy=%b expected 0 0", b1.out_valid, b1.busy);
        end
        tests_run++;
        if (b1.out_state !== 128'd0) begin
            tests_failed++; $display("FAIL reset_out_state: got %h expected 0", b1.out_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_forward_all();
        int lat1, lat2, lat4;
        logic [127:0] r1, r2, r4;
        lat1 = 0; lat2 = 0; lat4 = 0;
        r1 = '0; r2 = '0; r4 = '0;
        @(negedge clk);
        st = FWD_IN; inv = 1'b0; byp = 1'b0; ordy = 1'b1;
        v1 = 1'b1; v2 = 1'b1; v4 = 1'b1;
        @(posedge clk);
        #1 v1 = 1'b0; v2 = 1'b0; v4 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (b1.out_valid && lat1 == 0) begin lat1 = k; r1 = b1.out_state; end
            if (b2.out_valid && lat2 == 0) begin lat2 = k; r2 = b2.out_state; end
            if (b4.out_valid && lat4 == 0) begin lat4 = k; r4 = b4.out_state; end
        end
        tests_run++;
        if (lat1 !== 5) begin tests_failed++; $display("FAIL fwd_lat_cpc1: got %0d expected 5", lat1); end
        tests_run++;
        if (lat2 !== 3) begin tests_failed++; $display("FAIL fwd_lat_cpc2: got %0d expected 3", lat2); end
        tests_run++;
        if (lat4 !== 2) begin tests_failed++; $display("FAIL fwd_lat_cpc4: got %0d expected 2", lat4); end
        tests_run++;
        if (r1 !== FWD_OUT) begin tests_failed++; $display("FAIL fwd_data_cpc1: got %h expected %h", r1, FWD_OUT); end
        tests_run++;
        if (r2 !== FWD_OUT) begin tests_failed++; $display("FAIL fwd_data_cpc2: got %h expected %h", r2, FWD_OUT); end
        tests_run++;
        if (r4 !== FWD_OUT) begin tests_failed++; $display("FAIL fwd_data_cpc4: got %h expected %h", r4, FWD_OUT); end
    endtask

    task automatic test_inverse();
        logic [127:0] res;
        int lat;
        run_block(FWD_OUT, 1'b1, 1'b0, res, lat);
        tests_run++;
        if (res !== FWD_IN || lat !== 5) begin
            tests_failed++;
            $display("FAIL inv_vector: got %h lat %0d expected %h lat 5", res, lat, FWD_IN);
        end
        run_block(INV_IN, 1'b1, 1'b0, res, lat);
        tests_run++;
        if (res !== INV_OUT) begin
            tests_failed++; $display("FAIL inv_d5: got %h expected %h", res, INV_OUT);
        end
    endtask

    task automatic test_bypass();
        logic [127:0] res;
        int lat;
        run_block(BYP_IN, 1'b0, 1'b1, res, lat);
        tests_run++;
        if (res !== BYP_IN) begin tests_failed++; $display("FAIL bypass_data: got %h expected %h", res, BYP_IN); end
        tests_run++;
        if (lat !== 5) begin tests_failed++; $display("FAIL bypass_lat: got %0d expected 5", lat); end
    endtask

    task automatic test_backpressure();
        bit got;
        got = 1'b0;
        @(negedge clk);
        st = FWD_IN; inv = 1'b0; byp = 1'b0; ordy = 1'b0; v1 = 1'b1;
        @(posedge clk);
        #1 v1 = 1'b0;
        @(negedge clk);
        inv = 1'b1; byp = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (b1.out_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        tests_run++;
        if (!got) begin tests_failed++; $display("FAIL bp_done: got no out_valid expected out_valid"); end
        for (int k = 0; k < 10; k++) begin
            tests_run++;
            if (b1.out_state !== FWD_OUT || b1.in_ready !== 1'b0 || b1.out_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_hold: got state %h in_ready %b out_valid %b expected %h 0 1",
                         b1.out_state, b1.in_ready, b1.out_valid, FWD_OUT);
            end
            @(negedge clk);
        end
        ordy = 1'b1; inv = 1'b0; byp = 1'b0;
        @(negedge clk);
        tests_run++;
        if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: got in_ready %b out_valid %b expected 1 0", b1.in_ready, b1.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] vin [3];
        logic [127:0] vout [3];
        int acc [3];
        logic [127:0] res;
        bit got;
        vin[0] = FWD_IN;  vout[0] = FWD_OUT;
        vin[1] = MIX_IN;  vout[1] = MIX_OUT;
        vin[2] = C6;      vout[2] = C6;
        @(negedge clk);
        ordy = 1'b1; inv = 1'b0; byp = 1'b0; st = vin[0]; v1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 20; w++) begin
                if (b1.in_ready) break;
                @(negedge clk);
            end
            @(posedge clk);
            #1 acc[k] = cyc;
            @(negedge clk);
            if (k < 2) st = vin[k + 1];
            else       v1 = 1'b0;
            got = 1'b0;
            res = 128'd0;
            for (int w = 0; w < 20; w++) begin
                if (b1.out_valid) begin got = 1'b1; res = b1.out_state; break; end
                @(negedge clk);
            end
            tests_run++;
            if (!got || res !== vout[k]) begin
                tests_failed++;
                $display("FAIL b2b_data%0d: got %h expected %h", k, res, vout[k]);
            end
        end
        @(posedge clk);
        tests_run++;
        if (acc[1] - acc[0] !== 6) begin
            tests_failed++; $display("FAIL b2b_gap01: got %0d expected 6", acc[1] - acc[0]);
        end
        tests_run++;
        if (acc[2] - acc[1] !== 6) begin
            tests_failed++; $display("FAIL b2b_gap12: got %0d expected 6", acc[2] - acc[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] res;
        int lat;
        bit seen;
        @(negedge clk);
        st = FWD_IN; inv = 1'b0; byp = 1'b0; ordy = 1'b1; v1 = 1'b1;
        @(posedge clk);
        #1 v1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (b1.out_valid !== 1'b0 || b1.busy !== 1'b0 || b1.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_flags: got out_valid %b busy %b in_ready %b expected 0 0 1",
                     b1.out_valid, b1.busy, b1.in_ready);
        end
        tests_run++;
        if (b1.out_state !== 128'd0) begin
            tests_failed++; $display("FAIL rst_mid_state: got %h expected 0", b1.out_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (b1.out_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin tests_failed++; $display("FAIL rst_mid_ghost: got out_valid 1 expected 0"); end
        run_block(C6, 1'b0, 1'b0, res, lat);
        tests_run++;
        if (res !== C6 || lat !== 5) begin
            tests_failed++;
            $display("FAIL rst_mid_fresh: got %h lat %0d expected %h lat 5", res, lat, C6);
        end
    endtask

    initial begin
        test_reset();
        test_forward_all();
        test_inverse();
        test_bypass();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
